// File: rtl/seq_detect_param.sv
// ============================================================================
// Module   : seq_detect_param
// Brief    : Parametrised serial pattern detector with runtime pattern load,
//            overlapping/non-overlapping match mode and registered find pulse.
//            Optional macro SD_MATCH_CNT_EN adds a saturating match counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seq_detect_param #(
  parameter int                   PAT_LEN = 5,
  parameter logic [PAT_LEN-1:0]   PATTERN = 5'b10010,
  parameter bit                   OVERLAP = 1'b1,
  parameter int                   CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               data_valid,
  input  logic               data_in,
  input  logic               pat_load,
  input  logic [PAT_LEN-1:0] pat_in,
  output logic               find,
  output logic               busy_fill,
  output logic [CNT_W-1:0]   match_cnt
);

  localparam int FW = $clog2(PAT_LEN + 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(PAT_LEN);
  localparam logic [FW-1:0] FILL_ARM  = FW'(PAT_LEN - 1);

  logic [PAT_LEN-1:0] pat_reg;
  logic [PAT_LEN-1:0] sr;
  logic [FW-1:0]      fill;
  logic [PAT_LEN-1:0] window;
  logic               accept;
  logic               match;

  assign accept = data_valid && !pat_load;
  assign window = {sr[PAT_LEN-2:0], data_in};
  // fill gating keeps stale or reset-state bits in sr from forming a match
  assign match  = accept && (window == pat_reg) && (fill >= FILL_ARM);

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_reg   <= PATTERN;
      sr        <= '0;
      fill      <= '0;
      find      <= 1'b0;
      busy_fill <= 1'b1;
    end else if (pat_load) begin
      pat_reg   <= pat_in;
      fill      <= '0;
      find      <= 1'b0;
      busy_fill <= 1'b1;
    end else if (data_valid) begin
      sr   <= window;
      find <= match;
      if (match && !OVERLAP) begin
        fill      <= '0;
        busy_fill <= 1'b1;
      end else if (fill < FILL_FULL) begin
        fill      <= fill + FW'(1);
        busy_fill <= ((fill + FW'(1)) < FILL_FULL);
      end
    end else begin
      find <= 1'b0;
    end
  end

`ifdef SD_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst || pat_load) begin
      cnt_reg <= '0;
    end else if (match && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign match_cnt = cnt_reg;
`else
  assign match_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_seq_detect_param.sv
// ============================================================================
// Module   : tb_seq_detect_param
// Brief    : Bench for seq_detect_param; overlapping and non-overlapping
//            instances share one stimulus stream and a stream-history model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seq_detect_param;

  localparam int         PL   = 5;
  localparam logic [4:0] PAT0 = 5'b10010;
  localparam int         CW   = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          data_valid;
  logic          data_in;
  logic          pat_load;
  logic [PL-1:0] pat_in;
  logic          find_ov, find_no;
  logic          busy_ov, busy_no;
  logic [CW-1:0] cnt_ov, cnt_no;

  seq_detect_param #(.PAT_LEN(PL), .PATTERN(PAT0), .OVERLAP(1'b1), .CNT_W(CW)) u_ov (
    .clk(clk), .rst(rst), .data_valid(data_valid), .data_in(data_in),
    .pat_load(pat_load), .pat_in(pat_in),
    .find(find_ov), .busy_fill(busy_ov), .match_cnt(cnt_ov)
  );

  seq_detect_param #(.PAT_LEN(PL), .PATTERN(PAT0), .OVERLAP(1'b0), .CNT_W(CW)) u_no (
    .clk(clk), .rst(rst), .data_valid(data_valid), .data_in(data_in),
    .pat_load(pat_load), .pat_in(pat_in),
    .find(find_no), .busy_fill(busy_no), .match_cnt(cnt_no)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Model: every accepted bit since reset, and per instance the stream index
  // where its current window starts (moved by reset, load, non-overlap match).
  bit         stream[$];
  int         start[2];
  logic [4:0] m_pat;
  int         exp_find[2];
  int         exp_cnt[2];
  int         pulses[2];

  task automatic step(input bit r, input bit dv, input bit d, input bit pl,
                      input logic [4:0] pin);
    int n;
    logic [4:0] w;
    @(negedge clk);
    rst = r; data_valid = dv; data_in = d; pat_load = pl; pat_in = pin;
    if (r) begin
      stream.delete();
      m_pat = PAT0;
      for (int i = 0; i < 2; i++) begin
        start[i] = 0; exp_find[i] = 0; exp_cnt[i] = 0;
      end
    end else if (pl) begin
      m_pat = pin;
      for (int i = 0; i < 2; i++) begin
        start[i] = stream.size(); exp_find[i] = 0; exp_cnt[i] = 0;
      end
    end else if (dv) begin
      stream.push_back(d);
      n = stream.size();
      for (int i = 0; i < 2; i++) begin
        exp_find[i] = 0;
        if (n - start[i] >= PL) begin
          w = '0;
          for (int k = n - PL; k < n; k++) w = {w[3:0], stream[k]};
          if (w == m_pat) begin
            exp_find[i] = 1;
            if (exp_cnt[i] < (1 << CW) - 1) exp_cnt[i]++;
            if (i == 1) start[i] = n;
          end
        end
      end
    end else begin
      exp_find[0] = 0; exp_find[1] = 0;
    end
    @(posedge clk);
    #1;
    n = stream.size();
    check("find_ov", 32'(find_ov), 32'(exp_find[0]));
    check("find_no", 32'(find_no), 32'(exp_find[1]));
    check("busy_ov", 32'(busy_ov), 32'((n - start[0]) < PL));
    check("busy_no", 32'(busy_no), 32'((n - start[1]) < PL));
`ifdef SD_MATCH_CNT_EN
    check("cnt_ov", 32'(cnt_ov), 32'(exp_cnt[0]));
    check("cnt_no", 32'(cnt_no), 32'(exp_cnt[1]));
`else
    check("cnt_ov", 32'(cnt_ov), 32'h0);
    check("cnt_no", 32'(cnt_no), 32'h0);
`endif
    pulses[0] += int'(find_ov);
    pulses[1] += int'(find_no);
  endtask

  task automatic bits(input logic [31:0] v, input int len, input int gap);
    for (int i = len - 1; i >= 0; i--) begin
      step(1'b0, 1'b1, v[i], 1'b0, 5'h0);
      for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 1'b0, 1'b0, 5'h0);
    end
  endtask

  task automatic clr_pulses();
    pulses[0] = 0; pulses[1] = 0;
  endtask

  initial begin
    rst = 1'b1; data_valid = 1'b0; data_in = 1'b0; pat_load = 1'b0; pat_in = '0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'h0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 5'h0);
    check("rst_find", 32'(find_ov), 32'h0);
    check("rst_busy", 32'(busy_ov), 32'h1);

    // Plan 1/2: overlapping gets two matches, non-overlapping one
    clr_pulses();
    step(1'b0, 1'b0, 1'b0, 1'b0, 5'h0);
    bits(32'b10010010, 8, 0);
    check("t1_ov_pulses", 32'(pulses[0]), 32'd2);
    check("t2_no_pulses", 32'(pulses[1]), 32'd1);

    // Plan 3: gaps between valid bits
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'h0);
    clr_pulses();
    bits(32'b10010, 5, 3);
    check("t3_gap_pulses", 32'(pulses[0]), 32'd1);

    // Plan 4: fill gating with a zero-heavy pattern
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'h0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 5'b00010);
    clr_pulses();
    bits(32'b010, 3, 0);
    check("t4_gate_pulses", 32'(pulses[0]), 32'd0);
    bits(32'b00010, 5, 0);
    check("t4_match_pulses", 32'(pulses[0]), 32'd1);

    // Plan 5: reset mid-stream discards window and restores default pattern
    clr_pulses();
    bits(32'b100, 3, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 5'h0);
    bits(32'b10, 2, 0);
    check("t5_rst_pulses", 32'(pulses[0]), 32'd0);
    bits(32'b10010, 5, 0);
    check("t5_default_pat", 32'(pulses[1]), 32'd1);

    // Plan 6: load beats a simultaneous data bit, then counter saturation
    clr_pulses();
    step(1'b0, 1'b1, 1'b1, 1'b1, 5'b11011);
    bits(32'b11011, 5, 0);
    check("t6_load_pulses", 32'(pulses[0]), 32'd1);
    for (int i = 0; i < 5; i++) bits(32'b011, 3, 0);
    check("t6_more_pulses", 32'(pulses[0]), 32'd6);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      bit r, dv, d, pl;
      logic [4:0] p;
      r  = ($urandom_range(0, 99) == 0);
      pl = ($urandom_range(0, 49) == 0);
      dv = ($urandom_range(0, 3) != 0);
      d  = 1'($urandom);
      p  = ($urandom_range(0, 1) == 0) ? PAT0 : 5'($urandom);
      step(r, dv, d, pl, p);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
Parametrised serial pattern detector. It is the successor to the fixed 10010 detector and generalises pattern length and pattern value. It adds a qualified input (data_valid), a runtime pattern load, and selectable overlapping or non-overlapping match mode. It sits on a 1-bit serial stream and emits a one-cycle registered pulse per detected pattern for downstream status and control logic.

Parameters:
PAT_LEN, 5, pattern length in bits (legal range 2..32).
PATTERN, 5'b10010, reset/default pattern; MSB is the oldest bit received.
OVERLAP, 1, 1 = overlapping matches allowed; 0 = window restarts after each match.
CNT_W, 8, width of the match counter (used only with SD_MATCH_CNT_EN).

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
data_valid  input  1  qualifies data_in; bit accepted only when 1
data_in  input  1  serial data bit
pat_load  input  1  one-cycle strobe: load pat_in as the active pattern
pat_in  input  PAT_LEN  new pattern, MSB = oldest bit
find  output  1  one-cycle pulse: pattern completed by last accepted bit
busy_fill  output  1  1 while the window holds fewer than PAT_LEN valid bits
match_cnt  output  CNT_W  saturating match count (SD_MATCH_CNT_EN only)

Behaviour:
- Reset values (rst=1 at clk edge): pat_reg=PATTERN, shift register sr=0, fill=0, find=0, busy_fill=1, match_cnt=0. Reset has priority over every other input.
- Accepted bit: data_valid=1 and pat_load=0. On acceptance: sr <= {sr[PAT_LEN-2:0], data_in}; fill increments, saturating at PAT_LEN.
- Match condition, combinational on the current cycle: accepted bit, AND {sr[PAT_LEN-2:0], data_in} == pat_reg, AND fill >= PAT_LEN-1.
- fill gating prevents reset-state zeros in sr from forming false matches.
- find <= match condition; registered, latency 1 clk after the completing bit. find=0 in every cycle without a match, including cycles with data_valid=0.
- OVERLAP=1: fill is unaffected by a match; the next match may reuse the trailing bits.
- OVERLAP=0: on a match, fill <= 0. sr still shifts. The next match needs PAT_LEN fresh accepted bits.
- busy_fill = (fill < PAT_LEN), registered alongside fill.
- pat_load=1: pat_reg <= pat_in, fill <= 0, find <= 0. A data bit presented in the same cycle is discarded; load wins.
- data_valid=0: sr, fill and pat_reg are held.
- Reset mid-stream: all partial window content is discarded; no find from pre-reset bits.
- Internal structure: a fill counter of width clog2(PAT_LEN+1) plus the shift register. No explicit per-pattern FSM states; the fill counter forms the state (FILLING while fill<PAT_LEN, ARMED at fill=PAT_LEN).

Optional Feature:
SD_MATCH_CNT_EN
- Defined: match_cnt increments by 1 on every cycle where find is set (same edge as find), saturating at 2^CNT_W-1. Cleared by rst and by pat_load.
- Not defined: match_cnt port is still present, tied to 0. No counter flops are synthesised.

Test Plan:
1. Defaults, OVERLAP=1, data_valid=1, bits 1,0,0,1,0,0,1,0 -> find pulses exactly in the cycles after bit 5 and bit 8; nowhere else.
2. OVERLAP=0, same stream -> find only after bit 5. busy_fill returns to 1 the cycle after; no find after bit 8.
3. Gaps: bits 1,0,0,1,0 with data_valid=0 for 3 cycles between each bit -> single find, 1 clk after the final valid bit. sr and fill are held during the gaps.
4. Fill gating: PATTERN=5'b00010; after reset feed 0,1,0 -> no find. Continue 0,0,0,1,0 -> find after the last bit.
5. Reset mid-stream: 1,0,0, rst=1 for 1 cycle, then 1,0 -> no find. pat_reg reverts to PATTERN.
6. pat_load=1 with pat_in=5'b11011 and data_valid=1 in the same cycle (bit discarded), then 1,1,0,1,1 -> one find. With SD_MATCH_CNT_EN and CNT_W=2, five further matches -> match_cnt saturates at 3.
